// File: rtl/instr_issue_unit.sv
// -----------------------------------------------------------------------------
// instr_issue_unit
//
// Instruction fetch/issue sequencer for exe_engine. It reads a 32-bit word from
// instruction memory at PC and splits it into a 5-bit opcode and three 8-bit
// matrix addresses. It offers the instruction with a valid/ready handshake and
// then waits for exe_done before it fetches the next word. HALT_OP stops the
// sequencer. NOP_OP is skipped, but PC still advances past it.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               pulse, restarts fetching at PC=0 (honoured in IDLE/HALT)
//   mem_rd_en/mem_addr  one-cycle read strobe and address (= PC)
//   mem_rdata           instruction word, valid MEM_LAT cycles after mem_rd_en
//   instr, dst_addr,
//   src1_addr,
//   src2_addr           decoded fields; held stable while instr_valid is high
//   instr_valid/ready   issue handshake to the execution side
//   exe_done            pulse, the issued instruction has finished
//   busy, halted        status (busy = not IDLE/HALT)
//   pc_wrap             sticky, PC wrapped from max to 0 since last start
//   instr_count         instructions issued since last start, saturating
// -----------------------------------------------------------------------------
module instr_issue_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [4:0]  HALT_OP = 5'h1F,
  parameter logic [4:0]  NOP_OP  = 5'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            mem_rd_en,
  output logic [PC_W-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic [4:0]      instr,
  output logic [7:0]      dst_addr,
  output logic [7:0]      src1_addr,
  output logic [7:0]      src2_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            exe_done,
  output logic            busy,
  output logic            halted,
  output logic            pc_wrap,
  output logic [15:0]     instr_count
);

  localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_EXEC, S_HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc;
  logic [28:0]      ir;         // {opcode, dst, src1, src2}
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       opcode;
  logic             is_halt;
  logic             is_nop;
  logic             accept;
  logic             pc_adv;
  logic             restart;
  logic [2:0]       unused_bits;

  // Word bits 26:24 carry no field.
  assign unused_bits = mem_rdata[26:24];

  assign opcode  = ir[28:24];
  assign is_halt = (opcode == HALT_OP);
  assign is_nop  = !is_halt && (opcode == NOP_OP);
  assign accept  = (state == S_ISSUE) && instr_ready;
  assign pc_adv  = ((state == S_DECODE) && is_nop) || accept;
  assign restart = ((state == S_IDLE) || (state == S_HALT)) && start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments, so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path assigns state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_WAIT;
      S_WAIT:         if (wait_cnt == '0) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_halt)     state_nxt = S_HALT;
        else if (is_nop) state_nxt = S_FETCH;
        else             state_nxt = S_ISSUE;
      end
      S_ISSUE:        if (instr_ready) state_nxt = S_EXEC;
      S_EXEC:         if (exe_done) state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_rd_en   = (state == S_FETCH);
    instr_valid = (state == S_ISSUE);
    halted      = (state == S_HALT);
    busy        = (state != S_IDLE) && (state != S_HALT);
  end

  assign mem_addr  = pc;
  assign instr     = ir[28:24];
  assign dst_addr  = ir[23:16];
  assign src1_addr = ir[15:8];
  assign src2_addr = ir[7:0];

  // ---------------------------------------------------------------------------
  // Datapath: PC, wait counter, instruction register, statistics
  // ---------------------------------------------------------------------------
  // NOTE: the instruction register is reset like the control state, because
  // the decoded outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      ir          <= '0;
      wait_cnt    <= '0;
      pc_wrap     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (restart) begin
        pc          <= '0;
        pc_wrap     <= 1'b0;
        instr_count <= '0;
      end else if (pc_adv) begin
        pc <= pc + 1'b1;
        if (&pc) pc_wrap <= 1'b1;
      end

      // The counter covers the read latency. Capture happens in the last WAIT
      // cycle, which is exactly MEM_LAT cycles after the strobe.
      if (state == S_FETCH)
        wait_cnt <= CNT_LOAD;
      else if ((state == S_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;

      if ((state == S_WAIT) && (wait_cnt == '0))
        ir <= {mem_rdata[31:27], mem_rdata[23:0]};

      if (accept && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_unit
//
// Two instances of instr_issue_unit:
//   u_dut_a  default parameters (PC_W=8, MEM_LAT=1)
//   u_dut_b  PC_W=2, MEM_LAT=3 (PC wrap and longer read latency)
// Stimulus pushes the hand-decoded expected issues into a per-instance queue.
// A monitor per instance compares every valid cycle against the queue head and
// pops the head on each accepted handshake. Inputs change 2 time units after
// posedge. Outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_instr_issue_unit;

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] dst;
    logic [7:0] src1;
    logic [7:0] src2;
  } issue_t;

  localparam logic [31:0] HALT_W = 32'hF800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        a_reset, a_start, a_rd_en, a_valid, a_ready, a_exe_done;
  logic        a_busy, a_halted, a_wrap, a_auto;
  logic [7:0]  a_addr, a_dst, a_src1, a_src2;
  logic [4:0]  a_instr;
  logic [31:0] a_rdata;
  logic [15:0] a_count;
  logic [31:0] a_mem [256];
  issue_t      a_exp [$];
  logic [7:0]  a_fetch_q [$];

  instr_issue_unit u_dut_a (
    .clk(clk), .reset(a_reset), .start(a_start),
    .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .instr(a_instr), .dst_addr(a_dst), .src1_addr(a_src1), .src2_addr(a_src2),
    .instr_valid(a_valid), .instr_ready(a_ready), .exe_done(a_exe_done),
    .busy(a_busy), .halted(a_halted), .pc_wrap(a_wrap), .instr_count(a_count)
  );

  // Memory with 1-cycle read latency. The word is present only in that cycle.
  always @(posedge clk)
    a_rdata <= a_rd_en ? a_mem[a_addr] : 32'hDEAD_BEEF;

  // ---------------- instance B ----------------
  logic        b_reset, b_start, b_rd_en, b_valid, b_ready, b_exe_done;
  logic        b_busy, b_halted, b_wrap;
  logic [1:0]  b_addr;
  logic [7:0]  b_dst, b_src1, b_src2;
  logic [4:0]  b_instr;
  logic [31:0] b_rdata;
  logic [15:0] b_count;
  logic [31:0] b_mem [4];
  logic [31:0] b_pipe [3];
  issue_t      b_exp [$];

  instr_issue_unit #(.PC_W(2), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(b_reset), .start(b_start),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .instr(b_instr), .dst_addr(b_dst), .src1_addr(b_src1), .src2_addr(b_src2),
    .instr_valid(b_valid), .instr_ready(b_ready), .exe_done(b_exe_done),
    .busy(b_busy), .halted(b_halted), .pc_wrap(b_wrap), .instr_count(b_count)
  );

  // Memory with 3-cycle read latency. The word is present only in cycle 3.
  always @(posedge clk) begin
    b_pipe[0] <= b_rd_en ? b_mem[b_addr] : 32'hDEAD_BEEF;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rdata = b_pipe[2];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic issue_t mk(input logic [4:0] op, input logic [7:0] d,
                                input logic [7:0] s1, input logic [7:0] s2);
    issue_t r;
    r.op = op; r.dst = d; r.src1 = s1; r.src2 = s2;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic a_pulse_start;
    tick; a_start = 1'b1;
    tick; a_start = 1'b0;
  endtask

  task automatic b_pulse_start;
    tick; b_start = 1'b1;
    tick; b_start = 1'b0;
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, "_busy"},   a_busy,   0);
    check({tag, "_halted"}, a_halted, 0);
    check({tag, "_valid"},  a_valid,  0);
    check({tag, "_rd_en"},  a_rd_en,  0);
    check({tag, "_addr"},   a_addr,   0);
    check({tag, "_fields"}, {a_instr, a_dst, a_src1, a_src2}, 0);
    check({tag, "_wrap"},   a_wrap,   0);
    check({tag, "_count"},  a_count,  0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    issue_t cur;
    if (a_rd_en) a_fetch_q.push_back(a_addr);
    if (a_valid) begin
      cur = mk(a_instr, a_dst, a_src1, a_src2);
      check("a_sb_has_entry", a_exp.size() != 0, 1);
      if (a_exp.size() != 0) begin
        check("a_issue_fields", cur, a_exp[0]);
        if (a_ready) void'(a_exp.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    issue_t cur;
    if (b_valid) begin
      cur = mk(b_instr, b_dst, b_src1, b_src2);
      check("b_sb_has_entry", b_exp.size() != 0, 1);
      if (b_exp.size() != 0) begin
        check("b_issue_fields", cur, b_exp[0]);
        if (b_ready) void'(b_exp.pop_front());
      end
    end
  end

  // ---------------- exe_done responders (3 cycles after accept) ----------------
  initial begin
    a_exe_done = 1'b0;
    forever begin
      @(negedge clk);
      if (a_auto && a_valid && a_ready) begin
        repeat (3) @(posedge clk);
        #2 a_exe_done = 1'b1;
        tick;
        a_exe_done = 1'b0;
      end
    end
  end

  initial begin
    b_exe_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b_valid && b_ready) begin
        repeat (3) @(posedge clk);
        #2 b_exe_done = 1'b1;
        tick;
        b_exe_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    a_reset = 1'b1; a_start = 1'b0; a_ready = 1'b0; a_auto = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 256; i++) a_mem[i] = HALT_W;
    for (int i = 0; i < 4; i++)   b_mem[i] = HALT_W;

    tick; tick;
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    check_a_idle("reset");

    // ---- 1: reset mid-EXEC ----
    a_mem[0] = 32'h2844_5566;              // op 5, dst 44, src1 55, src2 66
    a_mem[1] = HALT_W;
    a_exp.push_back(mk(5'h05, 8'h44, 8'h55, 8'h66));
    a_ready = 1'b1;
    a_pulse_start;
    n = 0;
    while (!a_valid && n < 50) begin @(negedge clk); n++; end
    check("t1_issue_seen", a_valid, 1);
    @(negedge clk);
    check("t1_exec_busy",  a_busy,  1);
    check("t1_exec_valid", a_valid, 0);
    check("t1_exec_count", a_count, 1);
    check("t1_exec_pc",    a_addr,  1);
    tick; a_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_a_idle("t1_in_reset");
    tick; a_reset = 1'b0;
    @(negedge clk);
    check_a_idle("t1_after_reset");
    a_auto = 1'b1;

    // ---- 2: three-word program ----
    a_mem[0] = 32'h0803_0201;
    a_mem[1] = 32'h1001_0203;
    a_mem[2] = HALT_W;
    a_exp.push_back(mk(5'h01, 8'h03, 8'h02, 8'h01));
    a_exp.push_back(mk(5'h02, 8'h01, 8'h02, 8'h03));
    a_pulse_start;
    n = 0;
    while (!a_halted && n < 200) begin @(negedge clk); n++; end
    check("t2_halted", a_halted, 1);
    check("t2_busy",   a_busy,   0);
    check("t2_count",  a_count,  2);
    check("t2_pc",     a_addr,   2);
    check("t2_wrap",   a_wrap,   0);
    check("t2_sb_empty", a_exp.size(), 0);

    // ---- 3: backpressure ----
    a_mem[0] = 32'h1855_AA33;              // op 3, dst 55, src1 AA, src2 33
    a_mem[1] = HALT_W;
    a_exp.push_back(mk(5'h03, 8'h55, 8'hAA, 8'h33));
    a_ready = 1'b0;
    a_pulse_start;
    n = 0;
    while (!a_valid && n < 50) begin @(negedge clk); n++; end
    check("t3_issue_seen", a_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", a_valid, 1);
      check("t3_stall_pc",    a_addr,  0);
      check("t3_stall_count", a_count, 0);
      @(negedge clk);
    end
    tick; a_ready = 1'b1;
    n = 0;
    while (!a_halted && n < 200) begin @(negedge clk); n++; end
    check("t3_halted", a_halted, 1);
    check("t3_count",  a_count,  1);
    check("t3_pc",     a_addr,   1);

    // ---- 4: NOP skipped ----
    a_mem[0] = 32'h0012_3456;              // opcode 0: NOP
    a_mem[1] = 32'h2044_5566;              // op 4, dst 44, src1 55, src2 66
    a_mem[2] = HALT_W;
    a_exp.push_back(mk(5'h04, 8'h44, 8'h55, 8'h66));
    a_fetch_q.delete();
    a_pulse_start;
    n = 0;
    while (!a_halted && n < 200) begin @(negedge clk); n++; end
    check("t4_halted", a_halted, 1);
    check("t4_count",  a_count,  1);
    check("t4_fetches", a_fetch_q.size(), 3);
    if (a_fetch_q.size() == 3) begin
      check("t4_fetch0", a_fetch_q[0], 0);
      check("t4_fetch1", a_fetch_q[1], 1);
      check("t4_fetch2", a_fetch_q[2], 2);
    end
    check("a_sb_empty", a_exp.size(), 0);

    // ---- 6: MEM_LAT=3 latency, start while busy ----
    b_mem[0] = 32'h0801_0203;
    b_mem[1] = 32'h1004_0506;
    b_mem[2] = 32'h1807_0809;
    b_mem[3] = 32'h200A_0B0C;
    b_exp.push_back(mk(5'h01, 8'h01, 8'h02, 8'h03));
    b_exp.push_back(mk(5'h02, 8'h04, 8'h05, 8'h06));
    b_exp.push_back(mk(5'h03, 8'h07, 8'h08, 8'h09));
    b_exp.push_back(mk(5'h04, 8'h0A, 8'h0B, 8'h0C));
    b_pulse_start;
    @(negedge clk);
    n = 0;
    while (!b_rd_en && n < 20) begin @(negedge clk); n++; end
    check("t6_fetch_seen", b_rd_en, 1);
    n = 0;
    while (!b_valid && n < 20) begin @(negedge clk); n++; end
    check("t6_latency", n, 5);
    b_pulse_start;                          // issued while stalled in ISSUE
    @(negedge clk);
    check("t6_busy_start_valid", b_valid, 1);
    check("t6_busy_start_busy",  b_busy,  1);
    check("t6_busy_start_pc",    b_addr,  0);
    check("t6_busy_start_count", b_count, 0);

    // ---- 5: PC wrap with PC_W=2 ----
    tick; b_ready = 1'b1;
    n = 0;
    while (!b_wrap && n < 400) begin @(negedge clk); n++; end
    check("t5_wrap_set", b_wrap,  1);
    check("t5_wrap_pc",  b_addr,  0);
    check("t5_wrap_cnt", b_count, 4);
    b_mem[0] = HALT_W;                      // the next fetch at 0 halts
    n = 0;
    while (!b_halted && n < 200) begin @(negedge clk); n++; end
    check("t5_halted",     b_halted, 1);
    check("t5_halt_pc",    b_addr,   0);
    check("t5_halt_count", b_count,  4);
    check("t5_wrap_held",  b_wrap,   1);
    check("b_sb_empty",    b_exp.size(), 0);
    b_pulse_start;
    @(negedge clk);
    check("t5_restart_wrap",  b_wrap,  0);
    check("t5_restart_count", b_count, 0);
    n = 0;
    while (!b_halted && n < 200) begin @(negedge clk); n++; end
    check("t5_rehalted", b_halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
